// File: rtl/main_memory_responder.sv
// Responder side of the cache <-> main-memory four-phase handshake.
// One word per transaction through a word-organised store with a fixed access latency.
module main_memory_responder #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 32,
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic [DATA_WIDTH-1:0] writeData,
   input  logic                  readMem,
   input  logic                  writeMem,
   input  logic                  dataGrabbed,
   output logic                  memDataReady,
   output logic [DATA_WIDTH-1:0] readData,
   output logic                  busy
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);
   localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT    = 2'd1,
      READY   = 2'd2,
      RELEASE = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic                  op_wr_q, op_wr_d;
   logic                  ready_q, ready_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  mem_we;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];

   // Only the word-index bits select storage; the rest alias.
   generate
      if (ADDR_WIDTH > IDX_W + 2) begin : g_unused_hi
         logic unused_addr_bits;
         assign unused_addr_bits = ^{address[ADDR_WIDTH-1:IDX_W+2], address[1:0]};
      end else begin : g_unused_lo
         logic unused_addr_bits;
         assign unused_addr_bits = ^address[1:0];
      end
   endgenerate

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      wdata_d = wdata_q;
      op_wr_d = op_wr_q;
      ready_d = ready_q;
      rdata_d = rdata_q;
      mem_we  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (writeMem || readMem) begin
               idx_d   = address[IDX_W+1:2];
               wdata_d = writeData;
               op_wr_d = writeMem;
               cnt_d   = CNT_W'(LATENCY - 1);
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (cnt_q == '0) begin
               ready_d = 1'b1;
               state_d = READY;
               if (op_wr_q) begin
                  mem_we = 1'b1;
               end else begin
                  rdata_d = mem_q[idx_q];
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         READY: begin
            if (dataGrabbed) begin
               ready_d = 1'b0;
               state_d = RELEASE;
            end
         end
         RELEASE: begin
            if (!readMem && !writeMem && !dataGrabbed) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         wdata_q <= '0;
         op_wr_q <= 1'b0;
         ready_q <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         op_wr_q <= op_wr_d;
         ready_q <= ready_d;
         rdata_q <= rdata_d;
      end
   end

   // Storage is never cleared; a reset on the commit edge drops the write.
   always_ff @(posedge clk) begin
      if (rst && mem_we) begin
         mem_q[idx_q] <= wdata_q;
      end
   end

   assign memDataReady = ready_q;
   assign readData     = rdata_q;
   assign busy         = (state_q != IDLE);

endmodule
